// File: rtl/serial_subtractor4.sv
// ============================================================================
// Module      : serial_subtractor4
// Description : Bit-serial subtractor. It computes A - B - Bin one bit per
//               cycle, LSB first, and registers the result and the borrow-out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor4 #(
    parameter int Width = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [Width-1:0] InputA,
    input  logic [Width-1:0] InputB,
    input  logic             InputBorrow,
    output logic [Width-1:0] Output,
    output logic             OutputBorrow,
    output logic             Busy,
    output logic             Done
);

    localparam int                 C_CNT_W = $clog2(Width);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(Width - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q,  w_state_d;
    logic [Width-1:0]   r_a_q,      w_a_d;
    logic [Width-1:0]   r_b_q,      w_b_d;
    logic               r_br_q,     w_br_d;
    logic [Width-1:0]   r_res_q,    w_res_d;
    logic [C_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [Width-1:0]   r_out_q,    w_out_d;
    logic               r_obr_q,    w_obr_d;
    logic               r_busy_q,   w_busy_d;
    logic               r_done_q,   w_done_d;

    logic               w_diff_bit;
    logic               w_br_next;
    logic [Width-1:0]   w_res_shift;

    // One full-subtractor cell operating on the current LSBs.
    always_comb begin
        w_diff_bit  = r_a_q[0] ^ r_b_q[0] ^ r_br_q;
        w_br_next   = (~r_a_q[0] & r_b_q[0]) | (~(r_a_q[0] ^ r_b_q[0]) & r_br_q);
        w_res_shift = {w_diff_bit, r_res_q[Width-1:1]};
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_br_d    = r_br_q;
        w_res_d   = r_res_q;
        w_cnt_d   = r_cnt_q;
        w_out_d   = r_out_q;
        w_obr_d   = r_obr_q;

        case (r_state_q)
            S_IDLE: begin
                if (Start) begin
                    w_a_d     = InputA;
                    w_b_d     = InputB;
                    w_br_d    = InputBorrow;
                    w_res_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_a_d   = {1'b0, r_a_q[Width-1:1]};
                w_b_d   = {1'b0, r_b_q[Width-1:1]};
                w_br_d  = w_br_next;
                w_res_d = w_res_shift;
                w_cnt_d = r_cnt_q + C_CNT_W'(1);
                if (r_cnt_q == C_LAST) begin
                    w_out_d   = w_res_shift;
                    w_obr_d   = w_br_next;
                    w_cnt_d   = '0;
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Flags are registered copies of the next state, so they line up with it.
        w_busy_d = (w_state_d == S_RUN);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_br_q    <= 1'b0;
            r_res_q   <= '0;
            r_cnt_q   <= '0;
            r_out_q   <= '0;
            r_obr_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_br_q    <= w_br_d;
            r_res_q   <= w_res_d;
            r_cnt_q   <= w_cnt_d;
            r_out_q   <= w_out_d;
            r_obr_q   <= w_obr_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign Output       = r_out_q;
    assign OutputBorrow = r_obr_q;
    assign Busy         = r_busy_q;
    assign Done         = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor4.sv
// ============================================================================
// Module      : tb_serial_subtractor4
// Description : Self-checking bench for serial_subtractor4 with directed and
//               randomized operations compared against plain arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor4;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         InputBorrow;
    logic [W-1:0] Output;
    logic         OutputBorrow;
    logic         Busy;
    logic         Done;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] prev_out;
    logic         prev_br;

    serial_subtractor4 #(.Width(W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .InputA       (InputA),
        .InputB       (InputB),
        .InputBorrow  (InputBorrow),
        .Output       (Output),
        .OutputBorrow (OutputBorrow),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned subtraction with borrow, wrapped to W bits.
    function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
        int diff;
        diff = a - b - bin;
        ref_sub = {(a < b + bin) ? 1'b1 : 1'b0, W'(diff & ((1 << W) - 1))};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Launch from IDLE and follow the fixed timeline through DONE back to IDLE.
    // With disturb set, the operands change after launch and Start is re-pulsed mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input bit disturb, input string tag);
        logic [W:0] exp;
        exp         = ref_sub(int'(a), int'(b), int'(bin));
        InputA      = a;
        InputB      = b;
        InputBorrow = bin;
        Start       = 1'b1;
        tick();
        Start = 1'b0;
        if (disturb) begin
            InputA      = W'($urandom);
            InputB      = W'($urandom);
            InputBorrow = 1'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            check_eq({tag, ".busy"}, 32'(Busy), 32'd1);
            check_eq({tag, ".done"}, 32'(Done), 32'd0);
            check_eq({tag, ".hold"}, 32'({OutputBorrow, Output}), 32'({prev_br, prev_out}));
            Start = (disturb && (i == 1 || i == 2)) ? 1'b1 : 1'b0;
            tick();
        end
        Start = 1'b0;
        check_eq({tag, ".done_pulse"}, 32'({Busy, Done}), 32'b01);
        check_eq({tag, ".result"}, 32'({OutputBorrow, Output}), 32'(exp));
        prev_out = exp[W-1:0];
        prev_br  = exp[W];
        tick();
        check_eq({tag, ".idle"}, 32'({Busy, Done}), 32'b00);
        check_eq({tag, ".keep"}, 32'({OutputBorrow, Output}), 32'(exp));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;

        Reset       = 1'b1;
        Start       = 1'b0;
        InputA      = '0;
        InputB      = '0;
        InputBorrow = 1'b0;
        prev_out    = '0;
        prev_br     = 1'b0;
        tick();
        tick();
        check_eq("reset.outs", 32'({OutputBorrow, Output}), 32'd0);
        check_eq("reset.flags", 32'({Busy, Done}), 32'd0);
        Reset = 1'b0;
        tick();
        check_eq("idle.flags", 32'({Busy, Done}), 32'd0);

        run_op(4'b0000, 4'b0000, 1'b0, 1'b0, "zero");
        run_op(4'b0000, 4'b0001, 1'b0, 1'b0, "under_b");
        run_op(4'b0000, 4'b0000, 1'b1, 1'b0, "under_bin");
        run_op(4'b1010, 4'b0101, 1'b0, 1'b0, "alt1");
        run_op(4'b0101, 4'b1010, 1'b1, 1'b0, "alt2");
        run_op(4'b1111, 4'b1111, 1'b1, 1'b0, "max_bin");
        run_op(4'b1111, 4'b1110, 1'b1, 1'b0, "max_exact");
        run_op(4'b0110, 4'b0011, 1'b0, 1'b1, "disturb");
        run_op(4'b1001, 4'b0100, 1'b0, 1'b0, "relaunch");

        // Reset during RUN aborts without Done and clears the result.
        InputA = 4'b1100; InputB = 4'b0001; InputBorrow = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("abort.outs", 32'({OutputBorrow, Output}), 32'd0);
        check_eq("abort.flags", 32'({Busy, Done}), 32'd0);
        prev_out = '0;
        prev_br  = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check_eq("abort.no_done", 32'({Busy, Done}), 32'd0);
        end

        // Reset wins over Start on the same edge.
        Reset = 1'b1; Start = 1'b1;
        tick();
        check_eq("rst_start.busy", 32'(Busy), 32'd0);
        Reset = 1'b0; Start = 1'b0;
        tick();
        check_eq("rst_start.idle", 32'(Busy), 32'd0);

        for (int n = 0; n < 40; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor4.md
SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 The block SHALL have parameter Width, default 4, giving the operand and result width in bits; legal values are 2..16.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 The block SHALL have port Start, input, 1 bit: launches one subtraction when sampled high in IDLE.
REQ-005 The block SHALL have port InputA, input, Width bits: the minuend, captured at launch.
REQ-006 The block SHALL have port InputB, input, Width bits: the subtrahend, captured at launch.
REQ-007 The block SHALL have port InputBorrow, input, 1 bit: the borrow-in, captured at launch.
REQ-008 The block SHALL have port Output, output, Width bits: the registered difference of the last completed operation.
REQ-009 The block SHALL have port OutputBorrow, output, 1 bit: the registered borrow-out of the last completed operation.
REQ-010 The block SHALL have port Busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port Done, output, 1 bit: a one-cycle pulse marking that a result has been committed.

Function
REQ-012 The block SHALL implement three states, IDLE, RUN and DONE, held in a registered state machine.
REQ-013 In IDLE with Start=1, the block SHALL latch InputA, InputB and InputBorrow into internal shift/borrow registers, clear the bit counter to 0, and enter RUN.
REQ-014 In IDLE with Start=0, the block SHALL remain in IDLE and hold all outputs.
REQ-015 In RUN, the block SHALL process exactly one bit per cycle, LSB first, with no stall or early exit.
REQ-016 The per-bit rule SHALL be: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-017 In RUN, the block SHALL shift each d into a result shift register from the MSB side, so that after Width bits the result sits in natural bit order.
REQ-018 After the edge that processes bit Width-1, the block SHALL copy the result register to Output, copy the final borrow to OutputBorrow, and enter DONE.
REQ-019 In DONE, the block SHALL hold Done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: with Start sampled at edge N, Busy is high from edge N to edge N+Width, and Done is high from edge N+Width to edge N+Width+1.
REQ-021 Start SHALL be ignored in RUN and DONE; no queuing is performed, so the earliest relaunch is the Start sampled in the IDLE cycle after DONE.
REQ-022 Changes on InputA, InputB or InputBorrow after launch SHALL NOT affect the operation in progress.
REQ-023 Output and OutputBorrow SHALL stay stable during RUN, showing the previous result, and SHALL change only on the DONE transition.
REQ-024 The arithmetic SHALL be modulo 2^Width: Output = (InputA - InputB - InputBorrow) mod 2^Width, and OutputBorrow = 1 exactly when InputA < InputB + InputBorrow, evaluated unsigned.
REQ-025 Busy and Done SHALL never be high in the same cycle.

Reset
REQ-026 When Reset=1 is sampled, the block SHALL next-cycle enter IDLE with Output=0, OutputBorrow=0, Busy=0, Done=0, the counter and internal registers cleared.
REQ-027 Reset SHALL take priority over Start and over any state, including mid-RUN; an aborted operation SHALL produce no Done pulse and no Output update.
REQ-028 With Reset=1 and Start=1 on the same edge, the block SHALL stay in IDLE.

Verification (Width=4)
REQ-029 Scenario: A=0000, B=0000, Bin=0, Start pulse -> Busy for 4 cycles, Done at cycle 4, Output=0000, OutputBorrow=0.
REQ-030 Scenario: A=0000, B=0001, Bin=0 -> Output=1111, OutputBorrow=1; also A=0000, B=0000, Bin=1 -> Output=1111, OutputBorrow=1.
REQ-031 Scenario: A=1010, B=0101, Bin=0 -> Output=0101, OutputBorrow=0; then A=0101, B=1010, Bin=1 -> Output=1010, OutputBorrow=1.
REQ-032 Scenario: A=1111, B=1111, Bin=1 -> Output=1111, OutputBorrow=1; and A=1111, B=1110, Bin=1 -> Output=0000, OutputBorrow=0.
REQ-033 Scenario: launch A=0110, B=0011; change the inputs and pulse Start at cycle 2 -> Start ignored, result Output=0011 with a single Done; a new Start in the IDLE cycle after DONE is accepted.
REQ-034 Scenario: Reset asserted at cycle 2 of RUN -> no Done pulse, Output=0000, OutputBorrow=0, Busy=0 on the next cycle; a self-check compares every result against the reference arithmetic of REQ-024.
